mem_seq_ctrl: RTL and testbench
===============================

# mem_seq_ctrl

Load/store sequencer that sits between the CPU's memory-stage control signals (MemRead, MemWrite, funct3) and a byte-wide synchronous data RAM. It splits each LB/LH/LW/LBU/LHU/SB/SH/SW into 1, 2 or 4 little-endian byte transfers and assembles and extends load data. It stalls the pipeline until the access completes and flags misaligned or illegal accesses.

## Interface
- ADDR_WIDTH, 17, width of the byte address driven to the RAM (data space 0x00000–0x1FFFF).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory-stage access request; held stable with all request fields until `done`.
- req_read  in  1  MemRead from control.
- req_write  in  1  MemWrite from control.
- funct3  in  3  access size/extension (instr[14:12]).
- addr  in  32  effective address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  = req_valid & ~done; freezes the pipeline.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`; misaligned, illegal funct3, or read&write both set.
- rdata  out  32  extended load result; valid with `done`, held until next accept.
- mem_addr  out  ADDR_WIDTH  RAM byte address.
- mem_re  out  1  RAM read strobe; data returns on mem_rdata next cycle.
- mem_we  out  1  RAM byte write strobe.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte (1-cycle latency).

## Operation
- States: IDLE, XFER, DRAIN, RESP.
- IDLE: on req_valid & (req_read | req_write), capture addr[ADDR_WIDTH-1:0], wdata, funct3, dir; count←0.
  - Legal: go to XFER.
  - Error: go to RESP with err=1 and rdata=0, no RAM access.
- Size N: funct3 000/100 → 1, 001/101 → 2, 010 → 4.
- Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
- Misaligned: N=2 with addr[0]≠0, or N=4 with addr[1:0]≠0.
- XFER: mem_addr = base + count (mod 2^ADDR_WIDTH), count increments each cycle.
  - Store: mem_we=1, mem_wdata = wdata[8·count+7 : 8·count].
  - Load: mem_re=1; mem_rdata captured into byte (count−1) of the assembly register.
  - At count = N−1: stores go to RESP, loads go to DRAIN.
- DRAIN: capture byte N−1; go to RESP.
- RESP: done=1, rdata = extended assembly; go to IDLE.
- Extension:
  - LB: {24{b0[7]}, b0}
  - LBU: {24'b0, b0}
  - LH: {16{b1[7]}, b1, b0}
  - LHU: {16'b0, b1, b0}
  - LW: {b3, b2, b1, b0}
  - Stores: rdata = 0.
- If req_valid is still high in the IDLE cycle after RESP, it is a new request. The pipeline deasserts it on advance.

## Timing
- Accept cycle is cycle 0.
  - Store: XFER cycles 1..N, done in cycle N+1.
  - Load: XFER cycles 1..N, DRAIN N+1, done in cycle N+2.
  - Error: done in cycle 1.
- No RAM strobe outside XFER. mem_re and mem_we are never both high.
- Reset values: state IDLE; done, err, stall-internal, mem_re, mem_we = 0; mem_addr, mem_wdata, rdata = 0.
- Reset asserted mid-XFER: strobes drop asynchronously; a partial store is left in RAM and no done is produced.
- req_valid dropping mid-access is a protocol violation; the access still completes.
- mem_addr, mem_we and mem_re are decoded from registered state and count only, not from request inputs.

## Structure
- Package mem_seq_pkg:
  - state enum (IDLE, XFER, DRAIN, RESP).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - function size_of(funct3) returning N−1 as 2 bits.
- Sub-module mem_load_ext: combinational extension of the 32-bit assembly by funct3.
- Controller FSM, counter and assembly register live in mem_seq_ctrl.

## Test plan
- LW at 0x00104, RAM bytes 0x11, 0x22, 0x33, 0x84 → mem_re at 0x104..0x107 in cycles 1–4; done in cycle 6; rdata=0x84332211; err=0.
- LB / LBU at 0x00003, byte 0xF0 → rdata=0xFFFFFFF0 / 0x000000F0; done in cycle 3.
- SH at 0x00010 with wdata=0xDEADBEEF → mem_we writes 0xEF@0x10 then 0xBE@0x11; done in cycle 3; no write to 0x12.
- LW at 0x00102 → no RAM strobe; done in cycle 1 with err=1, rdata=0. Same for store funct3=100.
- Back-to-back SB 0x5A@0x20 then LBU@0x20 with req_valid held → second access returns 0x0000005A; stall low only in done cycles.
- rst_n low in XFER cycle 2 of an SW → mem_we low immediately; all outputs at reset values; next request after release completes normally.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the byte-serial load/store sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Number of byte transfers minus one; unknown codes map to a single byte.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: return 2'd1;
            F3_W:        return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the little-endian load assembly register.
module mem_load_ext
    import mem_seq_pkg::*;
(
    input  logic [31:0] asm_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = {{24{asm_i[7]}}, asm_i[7:0]};
            F3_BU:   data_o = {24'h000000, asm_i[7:0]};
            F3_H:    data_o = {{16{asm_i[15]}}, asm_i[15:0]};
            F3_HU:   data_o = {16'h0000, asm_i[15:0]};
            F3_W:    data_o = asm_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Splits LB/LH/LW/LBU/LHU/SB/SH/SW into byte transfers on a 1-cycle-latency RAM,
// stalls the pipeline for the duration and reports misaligned/illegal accesses.
//
// state | meaning
// IDLE  | waiting for a request; captures it on accept
// XFER  | one byte strobe per cycle, count = byte index
// DRAIN | last load byte returning from the RAM
// RESP  | done pulse, err/rdata valid
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    state_e                state_q, state_d;
    logic [1:0]            count_q, count_d;
    logic [1:0]            last_q, last_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic                  load_q, load_d;
    logic                  err_q, err_d;
    logic [31:0]           asm_q, asm_d;

    logic [1:0] req_last;
    logic [1:0] prev_idx;
    logic       ld_ok, st_ok, misal, acc_bad;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_WIDTH];

    assign req_last = size_of(funct3);
    assign ld_ok    = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    assign st_ok    = funct3 inside {F3_B, F3_H, F3_W};
    assign misal    = ((req_last == 2'd1) && addr[0]) ||
                      ((req_last == 2'd3) && (addr[1:0] != 2'b00));
    assign acc_bad  = (req_read && req_write) || (req_read ? !ld_ok : !st_ok) || misal;

    // Byte returned this cycle belongs to the strobe issued last cycle.
    assign prev_idx = count_q - 2'd1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        load_d  = load_q;
        err_d   = err_q;
        asm_d   = asm_q;

        case (state_q)
            IDLE: begin
                if (req_valid && (req_read || req_write)) begin
                    base_d  = addr[ADDR_WIDTH-1:0];
                    wdata_d = wdata;
                    f3_d    = funct3;
                    load_d  = req_read && !req_write;
                    last_d  = req_last;
                    count_d = 2'd0;
                    asm_d   = '0;
                    err_d   = acc_bad;
                    state_d = acc_bad ? RESP : XFER;
                end
            end
            XFER: begin
                if (load_q && (count_q != 2'd0)) begin
                    asm_d[{prev_idx, 3'b000} +: 8] = mem_rdata;
                end
                count_d = count_q + 2'd1;
                if (count_q == last_q) begin
                    state_d = load_q ? DRAIN : RESP;
                end
            end
            DRAIN: begin
                asm_d[{last_q, 3'b000} +: 8] = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            last_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            load_q  <= load_d;
            err_q   <= err_d;
            asm_q   <= asm_d;
        end
    end

    // RAM side is decoded purely from registered state so strobes drop with reset.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (state_q == XFER) begin
            mem_re   = load_q;
            mem_we   = !load_q;
            mem_addr = base_q + ADDR_WIDTH'(count_q);
            if (!load_q) begin
                mem_wdata = wdata_q[{count_q, 3'b000} +: 8];
            end
        end
    end

    assign done  = (state_q == RESP);
    assign err   = done && err_q;
    assign stall = req_valid && !done;

    mem_load_ext u_ext (
        .asm_i    (asm_q),
        .funct3_i (f3_q),
        .data_o   (rdata)
    );

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Table-driven bench for mem_seq_ctrl with a byte RAM model and a result scoreboard.
module tb_mem_seq_ctrl;
    import mem_seq_pkg::*;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [31:0]   addr = '0, wdata = '0;
    logic          stall, done, err;
    logic [31:0]   rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    always #5 clk = ~clk;

    mem_seq_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_read  (req_read),
        .req_write (req_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Byte RAM with 1-cycle read latency; bench preloads through its own port.
    logic [7:0]    ram [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [7:0]    pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic        hold;
    } vec_t;

    exp_t sb[$];
    vec_t vq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   b2b = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic add(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic e,
                       input logic [31:0] rdat, input int lat, input logic hold);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd;
        v.err = e; v.rdata = rdat; v.lat = lat; v.hold = hold;
        vq.push_back(v);
    endtask

    task automatic run(input vec_t v);
        exp_t          e, got;
        int            n;
        bit            seen;
        logic [AW-1:0] base;
        req_valid = 1'b1; req_read = v.rd; req_write = v.wr;
        funct3 = v.f3; addr = v.addr; wdata = v.wd;
        e.err = v.err; e.rdata = v.rdata; e.lat = v.lat;
        sb.push_back(e);
        if (b2b) begin
            @(posedge clk);
            @(negedge clk);
        end else begin
            #1;
        end
        chk({v.name, " stall c0"}, stall, 1);
        chk({v.name, " strobe c0"}, {mem_re, mem_we}, 0);
        n = v.err ? 0 : (v.rd ? v.lat - 2 : v.lat - 1);
        base = v.addr[AW-1:0];
        seen = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c <= n) begin
                chk({v.name, " mem_re"}, mem_re, v.rd);
                chk({v.name, " mem_we"}, mem_we, !v.rd);
                chk({v.name, " mem_addr"}, mem_addr, base + AW'(c - 1));
                if (!v.rd) chk({v.name, " mem_wdata"}, mem_wdata, v.wd[8*(c-1) +: 8]);
            end else begin
                chk({v.name, " no strobe"}, {mem_re, mem_we}, 0);
            end
            chk({v.name, " stall"}, stall, (c == v.lat) ? 0 : 1);
            if (done) begin
                seen = 1;
                got = sb.pop_front();
                chk({v.name, " latency"}, c, got.lat);
                chk({v.name, " err"}, err, got.err);
                chk({v.name, " rdata"}, rdata, got.rdata);
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: no done within 12 cycles", v.name);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        b2b = v.hold;
        if (!v.hold) begin
            req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if (mem_re && mem_we) begin
                n_fail++;
                $display("FAIL strobe overlap: mem_re=%b mem_we=%b required not both", mem_re, mem_we);
            end
        end
    end

    initial begin
        vec_t v;
        preload(17'h00003, 8'hF0);
        preload(17'h00104, 8'h11);
        preload(17'h00105, 8'h22);
        preload(17'h00106, 8'h33);
        preload(17'h00107, 8'h84);
        preload(17'h00010, 8'h00);
        preload(17'h00011, 8'h00);
        preload(17'h00012, 8'h77);
        preload(17'h00013, 8'h66);
        for (int i = 0; i < 4; i++) preload(AW'(32'h50 + i), 8'hAA);
        @(negedge clk);

        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset rdata", rdata, 0);
        chk("reset strobes", {mem_re, mem_we}, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset stall", stall, 0);
        rst_n = 1'b1;
        @(negedge clk);

        //   name          rd wr f3     addr           wdata          err rdata          lat hold
        add("lw_104",      1, 0, F3_W,  32'h00000104, 32'h0,         0, 32'h84332211, 6, 0);
        add("lb_003",      1, 0, F3_B,  32'h00000003, 32'h0,         0, 32'hFFFFFFF0, 3, 0);
        add("lbu_003",     1, 0, F3_BU, 32'h00000003, 32'h0,         0, 32'h000000F0, 3, 0);
        add("lh_106",      1, 0, F3_H,  32'h00000106, 32'h0,         0, 32'hFFFF8433, 4, 0);
        add("lhu_106",     1, 0, F3_HU, 32'h00000106, 32'h0,         0, 32'h00008433, 4, 0);
        add("lh_104",      1, 0, F3_H,  32'h00000104, 32'h0,         0, 32'h00002211, 4, 0);
        add("sh_010",      0, 1, F3_H,  32'h00000010, 32'hDEADBEEF,  0, 32'h00000000, 3, 0);
        add("lw_010",      1, 0, F3_W,  32'h00000010, 32'h0,         0, 32'h6677BEEF, 6, 0);
        add("lhu_hi_addr", 1, 0, F3_HU, 32'hFFFE0010, 32'h0,         0, 32'h0000BEEF, 4, 0);
        add("lw_misalign", 1, 0, F3_W,  32'h00000102, 32'h0,         1, 32'h00000000, 1, 0);
        add("st_f3_100",   0, 1, 3'b100,32'h00000020, 32'h12345678,  1, 32'h00000000, 1, 0);
        add("rd_and_wr",   1, 1, F3_W,  32'h00000104, 32'h0,         1, 32'h00000000, 1, 0);
        add("lh_misalign", 1, 0, F3_H,  32'h00000105, 32'h0,         1, 32'h00000000, 1, 0);
        add("ld_f3_011",   1, 0, 3'b011,32'h00000104, 32'h0,         1, 32'h00000000, 1, 0);
        add("sw_040",      0, 1, F3_W,  32'h00000040, 32'hCAFEF00D,  0, 32'h00000000, 5, 0);
        add("lw_040",      1, 0, F3_W,  32'h00000040, 32'h0,         0, 32'hCAFEF00D, 6, 0);
        add("sb_020_b2b",  0, 1, F3_B,  32'h00000020, 32'h0000005A,  0, 32'h00000000, 2, 1);
        add("lbu_020_b2b", 1, 0, F3_BU, 32'h00000020, 32'h0,         0, 32'h0000005A, 3, 0);
        foreach (vq[i]) run(vq[i]);

        // Reset during the second byte of a word store.
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        funct3 = F3_W; addr = 32'h00000050; wdata = 32'h11223344;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst pre mem_we", mem_we, 1);
        chk("rst pre mem_addr", mem_addr, 32'h51);
        rst_n = 1'b0;
        #1;
        chk("rst mem_we drop", mem_we, 0);
        req_valid = 1'b0; req_write = 1'b0;
        #1;
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst rdata", rdata, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst stall", stall, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst held idle", {done, mem_re, mem_we}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("partial store byte0", ram[17'h50], 8'h44);
        chk("partial store byte1", ram[17'h51], 8'hAA);
        b2b = 0;
        v.name = "lw_050_after_rst"; v.rd = 1; v.wr = 0; v.f3 = F3_W; v.addr = 32'h50;
        v.wd = 0; v.err = 0; v.rdata = 32'hAAAAAA44; v.lat = 6; v.hold = 0;
        run(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
